// File: rtl/id_issue_stage_pkg.sv
// Shared decode definitions for the ID/issue stage.
// - Opcode and funct constants for the supported MIPS-I integer subset.
// - Bit positions of the one-hot alu_op vector handed to EX.
// - BranchKind, which selects the redirect condition and target source.
// - IDToEXIssueBus, the decoded bundle passed from ID to EX.
package id_stage_params;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 12;

    // alu_op is one-hot; these are the bit positions.
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // REGIMM sub-opcodes carried in the rt field.
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_JUMP, BR_JREG
    } BranchKind;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     src1;
        logic [XLEN-1:0]     src2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     store_data;
        logic [4:0]          dest;
        logic [ALU_OP_W-1:0] alu_op;
        logic                register_write;
        logic                memory_read;
        logic                memory_write;
        BranchKind           branch_kind;
    } IDToEXIssueBus;

endpackage

// File: rtl/id_issue_stage_bypass_select.sv
// Operand forwarding mux for one source register.
// - reg_addr: architectural register being read.
// - byp_*: producer stages, index 0 youngest and highest priority.
// - rf_value: register-file value, already including the same-cycle WB write.
// - value: forwarded operand; blocked: newest producer has no result yet.
module id_bypass_select #(
    parameter int NUM_BYPASS = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic [4:0]                       reg_addr,
    input  logic [NUM_BYPASS-1:0]            byp_valid,
    input  logic [NUM_BYPASS-1:0]            byp_data_valid,
    input  logic [NUM_BYPASS*5-1:0]          byp_write_reg,
    input  logic [NUM_BYPASS*DATA_WIDTH-1:0] byp_write_data,
    input  logic [DATA_WIDTH-1:0]            rf_value,
    output logic [DATA_WIDTH-1:0]            value,
    output logic                             blocked
);

    logic hit;

    // Only the youngest matching producer counts: an older one with data
    // must not mask a younger one that is still computing.
    always_comb begin
        hit     = 1'b0;
        value   = rf_value;
        blocked = 1'b0;
        for (int i = 0; i < NUM_BYPASS; i++) begin
            if (!hit && byp_valid[i] && reg_addr != 5'd0 &&
                byp_write_reg[5*i +: 5] == reg_addr) begin
                hit = 1'b1;
                if (byp_data_valid[i])
                    value = byp_write_data[DATA_WIDTH*i +: DATA_WIDTH];
                else
                    blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode / operand-issue stage between IF and EX.
// - IF side: in_valid/in_instruction/in_program_count, id_allow_in.
// - EX side: out_valid/out_bundle, ex_allow_in.
// - Forwarding inputs byp_* and the WB register-file write port rf_*.
// - branch_taken/branch_target redirect IF once per instruction.
// - stall_cycles: saturating count of cycles held on an operand hazard.
//
// id_valid | branch_done | meaning
// 0        | 0           | stage empty
// 1        | 0           | holding an instruction, no redirect issued yet
// 1        | 1           | redirect issued, waiting for EX to accept
module id_issue_stage
    import id_stage_params::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_BYPASS  = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             ex_allow_in,
    output logic                             id_allow_in,
    input  logic                             in_valid,
    input  logic [31:0]                      in_instruction,
    input  logic [DATA_WIDTH-1:0]            in_program_count,
    input  logic [NUM_BYPASS-1:0]            byp_valid,
    input  logic [NUM_BYPASS-1:0]            byp_data_valid,
    input  logic [NUM_BYPASS*5-1:0]          byp_write_reg,
    input  logic [NUM_BYPASS*DATA_WIDTH-1:0] byp_write_data,
    input  logic                             rf_we,
    input  logic [4:0]                       rf_waddr,
    input  logic [DATA_WIDTH-1:0]            rf_wdata,
    output logic                             out_valid,
    output IDToEXIssueBus                    out_bundle,
    output logic                             branch_taken,
    output logic [DATA_WIDTH-1:0]            branch_target,
    output logic [STALL_CNT_W-1:0]           stall_cycles
);

    logic                   id_valid, branch_done, ready_go;
    logic [31:0]            instr;
    logic [DATA_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0]  rf [32];
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sa    = instr[10:6];
    assign funct = instr[5:0];
    assign imm16 = instr[15:0];

    always_ff @(posedge clock) begin
        if (rf_we && rf_waddr != 5'd0)
            rf[rf_waddr] <= rf_wdata;
    end

    // Reads see a WB write of the same cycle; register 0 is hardwired.
    function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [4:0] a);
        if (a == 5'd0)                 return '0;
        if (rf_we && rf_waddr == a)    return rf_wdata;
        return rf[a];
    endfunction

    logic [DATA_WIDTH-1:0] rs_val, rt_val;
    logic                  rs_blocked, rt_blocked;

    id_bypass_select #(.NUM_BYPASS(NUM_BYPASS), .DATA_WIDTH(DATA_WIDTH)) u_byp_rs (
        .reg_addr(rs), .byp_valid(byp_valid), .byp_data_valid(byp_data_valid),
        .byp_write_reg(byp_write_reg), .byp_write_data(byp_write_data),
        .rf_value(rf_read(rs)), .value(rs_val), .blocked(rs_blocked));

    id_bypass_select #(.NUM_BYPASS(NUM_BYPASS), .DATA_WIDTH(DATA_WIDTH)) u_byp_rt (
        .reg_addr(rt), .byp_valid(byp_valid), .byp_data_valid(byp_data_valid),
        .byp_write_reg(byp_write_reg), .byp_write_data(byp_write_data),
        .rf_value(rf_read(rt)), .value(rt_val), .blocked(rt_blocked));

    logic                  rs_used, rt_used, reg_write, mem_read, mem_write;
    logic [4:0]            dest;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] src1, src2, imm_ext;
    BranchKind             br_kind;

    assign imm_ext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};

    always_comb begin
        rs_used   = 1'b0;
        rt_used   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dest      = 5'd0;
        alu_op    = '0;
        src1      = rs_val;
        src2      = rt_val;
        br_kind   = BR_NONE;
        case (op)
            OP_SPECIAL: begin
                rs_used   = 1'b1;
                rt_used   = 1'b1;
                reg_write = 1'b1;
                dest      = rd;
                case (funct)
                    FUNCT_SLL:  begin rs_used = 1'b0; src1 = DATA_WIDTH'(sa); alu_op[ALU_SLL] = 1'b1; end
                    FUNCT_SRL:  begin rs_used = 1'b0; src1 = DATA_WIDTH'(sa); alu_op[ALU_SRL] = 1'b1; end
                    FUNCT_SRA:  begin rs_used = 1'b0; src1 = DATA_WIDTH'(sa); alu_op[ALU_SRA] = 1'b1; end
                    FUNCT_SLLV: alu_op[ALU_SLL]  = 1'b1;
                    FUNCT_SRLV: alu_op[ALU_SRL]  = 1'b1;
                    FUNCT_SRAV: alu_op[ALU_SRA]  = 1'b1;
                    FUNCT_ADDU: alu_op[ALU_ADD]  = 1'b1;
                    FUNCT_SUBU: alu_op[ALU_SUB]  = 1'b1;
                    FUNCT_AND:  alu_op[ALU_AND]  = 1'b1;
                    FUNCT_OR:   alu_op[ALU_OR]   = 1'b1;
                    FUNCT_XOR:  alu_op[ALU_XOR]  = 1'b1;
                    FUNCT_NOR:  alu_op[ALU_NOR]  = 1'b1;
                    FUNCT_SLT:  alu_op[ALU_SLT]  = 1'b1;
                    FUNCT_SLTU: alu_op[ALU_SLTU] = 1'b1;
                    FUNCT_JR: begin
                        rt_used = 1'b0; reg_write = 1'b0; dest = 5'd0; br_kind = BR_JREG;
                    end
                    FUNCT_JALR: begin
                        rt_used = 1'b0; br_kind = BR_JREG; alu_op[ALU_ADD] = 1'b1;
                        src1 = pc; src2 = DATA_WIDTH'(8);
                    end
                    default: begin
                        rs_used = 1'b0; rt_used = 1'b0; reg_write = 1'b0; dest = 5'd0;
                    end
                endcase
            end
            OP_REGIMM: begin
                rs_used = (rt == RT_BLTZ) || (rt == RT_BGEZ);
                br_kind = (rt == RT_BLTZ) ? BR_LTZ : (rt == RT_BGEZ) ? BR_GEZ : BR_NONE;
            end
            OP_J:    br_kind = BR_JUMP;
            OP_JAL: begin
                br_kind = BR_JUMP; reg_write = 1'b1; dest = 5'd31; alu_op[ALU_ADD] = 1'b1;
                src1 = pc; src2 = DATA_WIDTH'(8);
            end
            OP_BEQ:  begin rs_used = 1'b1; rt_used = 1'b1; br_kind = BR_EQ; end
            OP_BNE:  begin rs_used = 1'b1; rt_used = 1'b1; br_kind = BR_NE; end
            OP_BLEZ: begin rs_used = 1'b1; br_kind = BR_LEZ; end
            OP_BGTZ: begin rs_used = 1'b1; br_kind = BR_GTZ; end
            OP_ADDIU: begin
                rs_used = 1'b1; reg_write = 1'b1; dest = rt; alu_op[ALU_ADD] = 1'b1; src2 = imm_ext;
            end
            OP_LUI: begin
                reg_write = 1'b1; dest = rt; alu_op[ALU_LUI] = 1'b1;
                src1 = '0; src2 = DATA_WIDTH'({imm16, 16'h0000});
            end
            OP_LW: begin
                rs_used = 1'b1; reg_write = 1'b1; mem_read = 1'b1; dest = rt;
                alu_op[ALU_ADD] = 1'b1; src2 = imm_ext;
            end
            OP_SW: begin
                rs_used = 1'b1; rt_used = 1'b1; mem_write = 1'b1;
                alu_op[ALU_ADD] = 1'b1; src2 = imm_ext;
            end
            default: ;
        endcase
    end

    logic                  cond;
    logic [DATA_WIDTH-1:0] pc4;
    assign pc4 = pc + DATA_WIDTH'(4);

    always_comb begin
        case (br_kind)
            BR_EQ:   cond = (rs_val == rt_val);
            BR_NE:   cond = (rs_val != rt_val);
            BR_LEZ:  cond = ($signed(rs_val) <= 0);
            BR_GTZ:  cond = ($signed(rs_val) > 0);
            BR_LTZ:  cond = rs_val[DATA_WIDTH-1];
            BR_GEZ:  cond = !rs_val[DATA_WIDTH-1];
            BR_JUMP: cond = 1'b1;
            BR_JREG: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        case (br_kind)
            BR_JUMP: branch_target = {pc4[DATA_WIDTH-1:28], instr[25:0], 2'b00};
            BR_JREG: branch_target = rs_val;
            default: branch_target = pc4 + {imm_ext[DATA_WIDTH-3:0], 2'b00};
        endcase
    end

    assign ready_go     = !(rs_used && rs_blocked) && !(rt_used && rt_blocked);
    assign id_allow_in  = !id_valid || (ready_go && ex_allow_in);
    assign out_valid    = id_valid && ready_go && !flush;
    assign branch_taken = id_valid && ready_go && !branch_done && !flush && cond;
    assign stall_cycles = stall_cnt;

    always_comb begin
        out_bundle                = '0;
        out_bundle.pc             = pc;
        out_bundle.src1           = src1;
        out_bundle.src2           = src2;
        out_bundle.imm            = imm_ext;
        out_bundle.store_data     = rt_val;
        out_bundle.dest           = dest;
        out_bundle.alu_op         = alu_op;
        out_bundle.register_write = reg_write;
        out_bundle.memory_read    = mem_read;
        out_bundle.memory_write   = mem_write;
        out_bundle.branch_kind    = br_kind;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid    <= 1'b0;
            branch_done <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush) begin
                id_valid    <= 1'b0;
                branch_done <= 1'b0;
            end else if (id_allow_in) begin
                id_valid    <= in_valid;
                branch_done <= 1'b0;
                if (in_valid) begin
                    instr <= in_instruction;
                    pc    <= in_program_count;
                end
            end else if (branch_taken) begin
                // Held by EX: remember the redirect so it is not repeated.
                branch_done <= 1'b1;
            end
            if (id_valid && !ready_go && !(&stall_cnt))
                stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;
    import id_stage_params::*;

    logic          clock = 1'b0;
    logic          reset, flush, ex_allow_in, in_valid;
    logic [31:0]   in_instruction, in_program_count;
    logic [2:0]    byp_valid, byp_data_valid;
    logic [14:0]   byp_write_reg;
    logic [95:0]   byp_write_data;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          id_allow_in, out_valid, branch_taken;
    IDToEXIssueBus out_bundle;
    logic [31:0]   branch_target;
    logic [3:0]    stall_cycles;

    int total = 0;
    int bad   = 0;

    id_issue_stage #(.DATA_WIDTH(32), .NUM_BYPASS(3), .STALL_CNT_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ex_allow_in(ex_allow_in),
        .id_allow_in(id_allow_in), .in_valid(in_valid), .in_instruction(in_instruction),
        .in_program_count(in_program_count), .byp_valid(byp_valid),
        .byp_data_valid(byp_data_valid), .byp_write_reg(byp_write_reg),
        .byp_write_data(byp_write_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .out_valid(out_valid), .out_bundle(out_bundle),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stall_cycles(stall_cycles));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] pcv);
        in_valid = 1'b1; in_instruction = ins; in_program_count = pcv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_byp();
        byp_valid = '0; byp_data_valid = '0; byp_write_reg = '0; byp_write_data = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_allow_in = 1'b1; in_valid = 1'b0;
        in_instruction = '0; in_program_count = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        clear_byp();
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_allow", id_allow_in, 1);
        chk("rst_stall", stall_cycles, 0);
        reset = 1'b0;

        rf_write(1, 32'h1);
        rf_write(2, 32'h2);
        rf_write(4, 32'h1000);
        rf_write(6, 32'h8000_0000);
        rf_write(10, 32'h5);

        // load-use: addu $3,$2,$4 behind a lw $2 still in EX
        load(r_op(2, 4, 3, FUNCT_ADDU), 32'h200);
        byp_valid = 3'b001; byp_write_reg = 15'd2; byp_data_valid = 3'b000;
        #1;
        chk("lu_out_valid_stalled", out_valid, 0);
        chk("lu_allow_stalled", id_allow_in, 0);
        chk("lu_stall_before", stall_cycles, 0);
        tick();
        byp_data_valid = 3'b001; byp_write_data = 96'h55;
        #1;
        chk("lu_stall_count", stall_cycles, 1);
        chk("lu_out_valid", out_valid, 1);
        chk("lu_src1", out_bundle.src1, 32'h55);
        chk("lu_src2", out_bundle.src2, 32'h1000);
        chk("lu_dest", out_bundle.dest, 3);
        chk("lu_alu", out_bundle.alu_op, 12'h001);
        chk("lu_pc", out_bundle.pc, 32'h200);
        tick();
        clear_byp();
        #1;
        chk("lu_drained", out_valid, 0);

        // priority: or $7,$5,$0 ; byp0 and byp2 write $5, byp1 writes $0 (no data)
        load(r_op(5, 0, 7, FUNCT_OR), 32'h300);
        byp_valid = 3'b111; byp_data_valid = 3'b101;
        byp_write_reg = {5'd5, 5'd0, 5'd5};
        byp_write_data = {32'h22, 32'h33, 32'h11};
        #1;
        chk("pr_src1", out_bundle.src1, 32'h11);
        chk("pr_src2_zero", out_bundle.src2, 0);
        chk("pr_alu", out_bundle.alu_op, 12'h040);
        chk("pr_out_valid", out_valid, 1);
        tick();
        clear_byp();

        // same-cycle WB write forwarding: subu $8,$9,$10
        load(r_op(9, 10, 8, FUNCT_SUBU), 32'h340);
        rf_we = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'h77;
        #1;
        chk("wb_src1", out_bundle.src1, 32'h77);
        chk("wb_src2", out_bundle.src2, 32'h5);
        chk("wb_alu", out_bundle.alu_op, 12'h002);
        tick();
        rf_we = 1'b0;

        // bne $1,$2 under EX back-pressure: one redirect only
        load(i_op(OP_BNE, 1, 2, 16'h0004), 32'h100);
        ex_allow_in = 1'b0; in_valid = 1'b1; in_instruction = 32'h0; in_program_count = 32'h104;
        #1;
        chk("br_taken_1", branch_taken, 1);
        chk("br_target", branch_target, 32'h114);
        chk("br_allow_1", id_allow_in, 0);
        chk("br_out_valid_1", out_valid, 1);
        tick();
        chk("br_taken_2", branch_taken, 0);
        tick();
        chk("br_taken_3", branch_taken, 0);
        ex_allow_in = 1'b1;
        #1;
        chk("br_taken_4", branch_taken, 0);
        chk("br_allow_4", id_allow_in, 1);
        load(32'h0, 32'h104);
        chk("nop_out_valid", out_valid, 1);
        chk("nop_taken", branch_taken, 0);
        chk("nop_pc", out_bundle.pc, 32'h104);

        // jal with link
        load({OP_JAL, 26'h40}, 32'h400);
        in_valid = 1'b1; in_instruction = {OP_J, 26'h80}; in_program_count = 32'h404;
        #1;
        chk("jal_taken", branch_taken, 1);
        chk("jal_target", branch_target, 32'h100);
        chk("jal_dest", out_bundle.dest, 31);
        chk("jal_src1", out_bundle.src1, 32'h400);
        chk("jal_src2", out_bundle.src2, 8);
        chk("jal_rw", out_bundle.register_write, 1);
        tick();

        // flush with j held and a new word offered
        flush = 1'b1; in_valid = 1'b1; in_instruction = r_op(1, 2, 3, FUNCT_ADDU);
        in_program_count = 32'h408;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_taken", branch_taken, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_after_valid", out_valid, 0);
        chk("fl_after_taken", branch_taken, 0);
        chk("fl_after_allow", id_allow_in, 1);

        // sw $4,-4($1)
        load(i_op(OP_SW, 1, 4, 16'hFFFC), 32'h700);
        chk("sw_src1", out_bundle.src1, 32'h1);
        chk("sw_src2", out_bundle.src2, 32'hFFFF_FFFC);
        chk("sw_store", out_bundle.store_data, 32'h1000);
        chk("sw_mw", out_bundle.memory_write, 1);
        chk("sw_rw", out_bundle.register_write, 0);
        tick();

        // undecoded opcode flows as a bubble
        load({6'h3F, 26'h0}, 32'h720);
        chk("ud_valid", out_valid, 1);
        chk("ud_rw", out_bundle.register_write, 0);
        chk("ud_mw", out_bundle.memory_write, 0);
        chk("ud_taken", branch_taken, 0);
        tick();

        // signed compares against zero with rs = 0x80000000
        load(i_op(OP_REGIMM, 6, RT_BGEZ, 16'h0004), 32'h600);
        chk("bgez_taken", branch_taken, 0);
        tick();
        load(i_op(OP_REGIMM, 6, RT_BLTZ, 16'h0004), 32'h600);
        chk("bltz_taken", branch_taken, 1);
        chk("bltz_target", branch_target, 32'h614);
        tick();

        // reset while stalled
        load(r_op(2, 4, 3, FUNCT_ADDU), 32'h200);
        byp_valid = 3'b001; byp_write_reg = 15'd2; byp_data_valid = 3'b000;
        tick(); tick();
        chk("rs_stall_before", stall_cycles, 3);
        chk("rs_allow_before", id_allow_in, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_stall", stall_cycles, 0);
        chk("rs_allow", id_allow_in, 1);

        // saturation: 20 stalled cycles on a 4-bit counter
        load(r_op(2, 4, 3, FUNCT_ADDU), 32'h200);
        repeat (20) tick();
        chk("sat_stall", stall_cycles, 15);
        chk("sat_allow", id_allow_in, 0);
        byp_data_valid = 3'b001; byp_write_data = 96'h55;
        #1;
        chk("sat_release", out_valid, 1);
        tick();
        clear_byp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
